command_word_sequencer_8259: RTL
================================

// Module: command_word_sequencer_8259
// PURPOSE: Consumes the decoded write strobes and internal_data_bus from the 8259 data-bus control stage.
//   Runs the ICW1->ICW2->[ICW3]->[ICW4] initialization sequence, then holds the OCW1/2/3 state.
//   Drives the configuration, mask and command pulses used by the priority resolver and in-service logic.
// PARAMETERS:
//   MASK_RESET             8'hFF  interrupt_mask value after reset (ICW1 clears it to 8'h00)
//   LOWEST_PRIORITY_RESET  3'd7   lowest_priority_level after reset and after ICW1
// PORTS:
//   clock                           in   1  single clock for all state
//   reset                           in   1  synchronous, active-high
//   internal_data_bus               in   8  write data from bus control
//   write_initial_command_word_1    in   1  ICW1 strobe (level; event = rising edge)
//   write_initial_command_word_2_4  in   1  ICW2/3/4 strobe (level; event = rising edge)
//   write_operation_control_word_1  in   1  OCW1 strobe
//   write_operation_control_word_2  in   1  OCW2 strobe
//   write_operation_control_word_3  in   1  OCW3 strobe
//   read                            in   1  CPU read strobe (clears poll_pending)
//   init_done                       out  1  high in READY
//   icw1_config                     out  4  {LTIM,ADI,SNGL,IC4} = ICW1[3:0]
//   vector_base                     out  5  ICW2[7:3]
//   cascade_config                  out  8  ICW3 (00 if SNGL)
//   icw4_config                     out  5  {SFNM,BUF,M/S,AEOI,uPM} = ICW4[4:0]; 00 if IC4=0
//   interrupt_mask                  out  8  OCW1
//   nonspecific_eoi                 out  1  1-cycle pulse
//   specific_eoi                    out  1  1-cycle pulse; eoi_level valid in the same cycle
//   eoi_level                       out  3  OCW2[2:0] of the last specific/rotate/set-priority command
//   rotate_on_eoi                   out  1  1-cycle pulse, qualifies the eoi pulse in the same cycle
//   auto_rotate_mode                out  1  rotate-in-AEOI flag
//   lowest_priority_level           out  3  set-priority register
//   special_mask_mode               out  1  OCW3 SMM state
//   read_isr_select                 out  1  0=IRR, 1=ISR for the status read
//   poll_pending                    out  1  poll command outstanding (macro only)
// BEHAVIOUR:
// - Reset: state IDLE, init_done=0, all configs/level/flags/pulses 0, mask=MASK_RESET, lowest=LOWEST_PRIORITY_RESET.
//   Strobe history regs reset to 1: a strobe held high across reset release is not an event.
// - Event = strobe & ~strobe_q. Registers update on the event edge; outputs are visible 1 clock after the strobe is sampled high.
// - FSM states: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
// - ICW1 event in any state: ->WAIT_ICW2; latch icw1_config; clear mask/cascade/icw4/SMM/auto_rotate/read_isr/poll_pending.
//   Set lowest=LOWEST_PRIORITY_RESET. init_done=0.
// - ICW2_4 event: WAIT_ICW2 latches vector_base, then ->WAIT_ICW3 if !SNGL, else WAIT_ICW4 if IC4, else READY.
//   WAIT_ICW3 latches cascade, then ->WAIT_ICW4 if IC4, else READY. WAIT_ICW4 latches icw4_config, then ->READY.
//   Ignored in IDLE and READY.
// - OCW events are honoured only in READY and ignored elsewhere. OCW1: mask <= bus.
// - OCW2 {R,SL,EOI}=bus[7:5]:
//     001 nonspecific_eoi
//     011 specific_eoi + eoi_level
//     101 nonspecific_eoi + rotate_on_eoi
//     111 specific_eoi + rotate_on_eoi + eoi_level
//     100 auto_rotate_mode=1
//     000 auto_rotate_mode=0
//     110 lowest=bus[2:0]
//     010 no-op
// - OCW3: bus[6]=1 -> special_mask_mode=bus[5]; bus[1]=1 -> read_isr_select=bus[0].
// - Simultaneous events: ICW1 beats all others; multiple OCW strobes in one cycle are a protocol error, priority OCW1>OCW2>OCW3.
// - Pulses are exactly 1 cycle regardless of strobe length.
// CONFIGURATION: macro PIC_POLL_COMMAND_EN.
//   Defined: OCW3 with bus[2]=1 sets poll_pending; the rising edge of read clears it. Set wins over clear in the same cycle.
//   Undefined: bus[2] is ignored and poll_pending is tied 0.
// STRUCTURE:
//   Package pic8259_pkg: state enum, OCW2 {R,SL,EOI} code localparams, ICW1/ICW4 bit-index constants.
//   Sub-module strobe_edge_detect_8259: six instances, each a history reg plus a rising-edge pulse.
// TESTING:
// - Reset with strobes low -> mask=FF, lowest=7, init_done=0, state IDLE.
// - ICW1=8'h13, ICW2=8'h20, ICW4=8'h03 -> vector_base=5'h04, ICW3 skipped, icw4_config=5'h03, init_done=1. ICW2_4 in READY -> no change.
// - ICW1=8'h11, ICW2=8'h08, ICW3=8'h04, ICW4=8'h01 -> cascade=8'h04, init_done=1. An ICW1 mid-sequence restarts at WAIT_ICW2 with mask=00.
// - READY: OCW1=8'hA5 -> mask=A5; OCW2=8'h63 -> specific_eoi 1 cycle, eoi_level=3; OCW2=8'hC5 -> lowest=5; OCW2=8'hA0 -> both pulses.
// - OCW3=8'h68 -> SMM=1; OCW3=8'h0B -> read_isr_select=1. Strobe held 10 clocks -> one update only.
// - PIC_POLL_COMMAND_EN defined: OCW3=8'h0C -> poll_pending=1 until read rises. Undefined -> poll_pending stays 0.

Source files
------------

// File: rtl/command_word_sequencer_8259_pkg.sv
// Shared types and constants for the 8259 command-word sequencer:
// FSM state encoding, OCW2 {R,SL,EOI} command codes, ICW bit positions
// and the index of each strobe in the edge-detector vector.
package pic8259_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ICW2,
        ST_WAIT_ICW3,
        ST_WAIT_ICW4,
        ST_READY
    } state_t;

    // OCW2 command codes, taken from bus[7:5] = {R,SL,EOI}
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    // ICW1 / ICW4 bit positions
    localparam int ICW1_IC4       = 0;
    localparam int ICW1_SNGL      = 1;
    localparam int ICW1_FIELD_MSB = 3;
    localparam int ICW4_FIELD_MSB = 4;

    // Position of each strobe in the edge-detector vector
    localparam int STB_ICW1    = 0;
    localparam int STB_ICW2_4  = 1;
    localparam int STB_OCW1    = 2;
    localparam int STB_OCW2    = 3;
    localparam int STB_OCW3    = 4;
    localparam int STB_READ    = 5;
    localparam int NUM_STROBES = 6;

endpackage

// File: rtl/command_word_sequencer_8259_if.sv
// Bus between the 8259 data-bus control stage (master) and the
// command-word sequencer (slave): write strobes and data in,
// configuration / mask / command pulses out.
interface command_word_sequencer_8259_if;

    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       read;

    logic       init_done;
    logic [3:0] icw1_config;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic [4:0] icw4_config;
    logic [7:0] interrupt_mask;
    logic       nonspecific_eoi;
    logic       specific_eoi;
    logic [2:0] eoi_level;
    logic       rotate_on_eoi;
    logic       auto_rotate_mode;
    logic [2:0] lowest_priority_level;
    logic       special_mask_mode;
    logic       read_isr_select;
    logic       poll_pending;

    modport master (
        output internal_data_bus, write_initial_command_word_1,
               write_initial_command_word_2_4, write_operation_control_word_1,
               write_operation_control_word_2, write_operation_control_word_3, read,
        input  init_done, icw1_config, vector_base, cascade_config, icw4_config,
               interrupt_mask, nonspecific_eoi, specific_eoi, eoi_level,
               rotate_on_eoi, auto_rotate_mode, lowest_priority_level,
               special_mask_mode, read_isr_select, poll_pending
    );

    modport slave (
        input  internal_data_bus, write_initial_command_word_1,
               write_initial_command_word_2_4, write_operation_control_word_1,
               write_operation_control_word_2, write_operation_control_word_3, read,
        output init_done, icw1_config, vector_base, cascade_config, icw4_config,
               interrupt_mask, nonspecific_eoi, specific_eoi, eoi_level,
               rotate_on_eoi, auto_rotate_mode, lowest_priority_level,
               special_mask_mode, read_isr_select, poll_pending
    );

endinterface

// File: rtl/command_word_sequencer_8259_strobe_edge_detect.sv
// Rising-edge detector for one level write strobe: a history register
// plus a combinational one-cycle event.
module strobe_edge_detect_8259 (
    input  logic clock,
    input  logic reset,
    input  logic i_strobe,
    output logic o_event
);

    logic r_strobe_q;

    // Strobe history; event is strobe high now and low last cycle
    always_ff @(posedge clock) begin
        // NOTE: history resets to 1 so a strobe already high when reset is released does not count as an event.
        if (reset) r_strobe_q <= 1'b1;
        else       r_strobe_q <= i_strobe;
    end

    assign o_event = i_strobe & ~r_strobe_q;

endmodule

// File: rtl/command_word_sequencer_8259.sv
// 8259 command-word sequencer: runs ICW1->ICW2->[ICW3]->[ICW4], then
// holds OCW1/2/3 state and issues EOI / rotate command pulses.
// Optional feature: define PIC_POLL_COMMAND_EN to enable the OCW3 poll
// command (poll_pending set by OCW3 bus[2], cleared by rising read).
module command_word_sequencer_8259
    import pic8259_pkg::*;
#(
    parameter logic [7:0] MASK_RESET            = 8'hFF,
    parameter logic [2:0] LOWEST_PRIORITY_RESET = 3'd7
) (
    input  logic                           clock,
    input  logic                           reset,
    command_word_sequencer_8259_if.slave   bus
);

    logic [NUM_STROBES-1:0] w_strobe;
    logic [NUM_STROBES-1:0] w_event;

    state_t     r_state;
    logic       r_init_done;
    logic [3:0] r_icw1_config;
    logic [4:0] r_vector_base;
    logic [7:0] r_cascade_config;
    logic [4:0] r_icw4_config;
    logic [7:0] r_interrupt_mask;
    logic       r_nonspecific_eoi;
    logic       r_specific_eoi;
    logic [2:0] r_eoi_level;
    logic       r_rotate_on_eoi;
    logic       r_auto_rotate_mode;
    logic [2:0] r_lowest_priority_level;
    logic       r_special_mask_mode;
    logic       r_read_isr_select;
    logic       r_poll_pending;

    assign w_strobe[STB_ICW1]   = bus.write_initial_command_word_1;
    assign w_strobe[STB_ICW2_4] = bus.write_initial_command_word_2_4;
    assign w_strobe[STB_OCW1]   = bus.write_operation_control_word_1;
    assign w_strobe[STB_OCW2]   = bus.write_operation_control_word_2;
    assign w_strobe[STB_OCW3]   = bus.write_operation_control_word_3;
    assign w_strobe[STB_READ]   = bus.read;

    for (genvar g = 0; g < NUM_STROBES; g++) begin : g_edge
        strobe_edge_detect_8259 u_edge (
            .clock    (clock),
            .reset    (reset),
            .i_strobe (w_strobe[g]),
            .o_event  (w_event[g])
        );
    end

    // Init-sequence FSM plus all configuration, mask and pulse registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                 <= ST_IDLE;
            r_init_done             <= 1'b0;
            r_icw1_config           <= '0;
            r_vector_base           <= '0;
            r_cascade_config        <= '0;
            r_icw4_config           <= '0;
            r_interrupt_mask        <= MASK_RESET;
            r_nonspecific_eoi       <= 1'b0;
            r_specific_eoi          <= 1'b0;
            r_eoi_level             <= '0;
            r_rotate_on_eoi         <= 1'b0;
            r_auto_rotate_mode      <= 1'b0;
            r_lowest_priority_level <= LOWEST_PRIORITY_RESET;
            r_special_mask_mode     <= 1'b0;
            r_read_isr_select       <= 1'b0;
            r_poll_pending          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let later statements override the pulse defaults below without ordering hazards.
            r_nonspecific_eoi <= 1'b0;
            r_specific_eoi    <= 1'b0;
            r_rotate_on_eoi   <= 1'b0;
            if (w_event[STB_READ]) r_poll_pending <= 1'b0;

            if (w_event[STB_ICW1]) begin
                r_state                 <= ST_WAIT_ICW2;
                r_init_done             <= 1'b0;
                r_icw1_config           <= bus.internal_data_bus[ICW1_FIELD_MSB:0];
                r_interrupt_mask        <= 8'h00;
                r_cascade_config        <= '0;
                r_icw4_config           <= '0;
                r_special_mask_mode     <= 1'b0;
                r_auto_rotate_mode      <= 1'b0;
                r_read_isr_select       <= 1'b0;
                r_poll_pending          <= 1'b0;
                r_lowest_priority_level <= LOWEST_PRIORITY_RESET;
            end else begin
                if (w_event[STB_ICW2_4]) begin
                    case (r_state)
                        ST_WAIT_ICW2: begin
                            r_vector_base <= bus.internal_data_bus[7:3];
                            if (!r_icw1_config[ICW1_SNGL]) begin
                                r_state <= ST_WAIT_ICW3;
                            end else if (r_icw1_config[ICW1_IC4]) begin
                                r_state <= ST_WAIT_ICW4;
                            end else begin
                                r_state     <= ST_READY;
                                r_init_done <= 1'b1;
                            end
                        end
                        ST_WAIT_ICW3: begin
                            r_cascade_config <= bus.internal_data_bus;
                            if (r_icw1_config[ICW1_IC4]) begin
                                r_state <= ST_WAIT_ICW4;
                            end else begin
                                r_state     <= ST_READY;
                                r_init_done <= 1'b1;
                            end
                        end
                        ST_WAIT_ICW4: begin
                            r_icw4_config <= bus.internal_data_bus[ICW4_FIELD_MSB:0];
                            r_state       <= ST_READY;
                            r_init_done   <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                // Operation control words only take effect once initialised
                if (r_state == ST_READY) begin
                    if (w_event[STB_OCW1]) begin
                        r_interrupt_mask <= bus.internal_data_bus;
                    end else if (w_event[STB_OCW2]) begin
                        case (bus.internal_data_bus[7:5])
                            OCW2_NS_EOI: r_nonspecific_eoi <= 1'b1;
                            OCW2_SP_EOI: begin
                                r_specific_eoi <= 1'b1;
                                r_eoi_level    <= bus.internal_data_bus[2:0];
                            end
                            OCW2_ROT_NS_EOI: begin
                                r_nonspecific_eoi <= 1'b1;
                                r_rotate_on_eoi   <= 1'b1;
                            end
                            OCW2_ROT_SP_EOI: begin
                                r_specific_eoi  <= 1'b1;
                                r_rotate_on_eoi <= 1'b1;
                                r_eoi_level     <= bus.internal_data_bus[2:0];
                            end
                            OCW2_ROT_AEOI_SET: r_auto_rotate_mode <= 1'b1;
                            OCW2_ROT_AEOI_CLR: r_auto_rotate_mode <= 1'b0;
                            OCW2_SET_PRIO: begin
                                r_lowest_priority_level <= bus.internal_data_bus[2:0];
                                r_eoi_level             <= bus.internal_data_bus[2:0];
                            end
                            default: ;
                        endcase
                    end else if (w_event[STB_OCW3]) begin
                        if (bus.internal_data_bus[6]) r_special_mask_mode <= bus.internal_data_bus[5];
                        if (bus.internal_data_bus[1]) r_read_isr_select   <= bus.internal_data_bus[0];
`ifdef PIC_POLL_COMMAND_EN
                        if (bus.internal_data_bus[2]) r_poll_pending <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign bus.init_done             = r_init_done;
    assign bus.icw1_config           = r_icw1_config;
    assign bus.vector_base           = r_vector_base;
    assign bus.cascade_config        = r_cascade_config;
    assign bus.icw4_config           = r_icw4_config;
    assign bus.interrupt_mask        = r_interrupt_mask;
    assign bus.nonspecific_eoi       = r_nonspecific_eoi;
    assign bus.specific_eoi          = r_specific_eoi;
    assign bus.eoi_level             = r_eoi_level;
    assign bus.rotate_on_eoi         = r_rotate_on_eoi;
    assign bus.auto_rotate_mode      = r_auto_rotate_mode;
    assign bus.lowest_priority_level = r_lowest_priority_level;
    assign bus.special_mask_mode     = r_special_mask_mode;
    assign bus.read_isr_select       = r_read_isr_select;
    // Without the poll feature this register is never set and stays 0
    assign bus.poll_pending          = r_poll_pending;

endmodule
